// File: rtl/dmem_arbiter_pkg.sv
// Shared core definitions: arbiter FSM states, access owner IDs and the
// control-unit phase constants that drive the arbiter's requesters.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    CU_FETCH   = 2'd0,
    CU_DECODE  = 2'd1,
    CU_EXECUTE = 2'd2,
    CU_WRITE   = 2'd3
  } cu_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between instruction fetch and load/store.
// One access at a time: arbitrate, issue, wait fixed read latency, respond.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        state_dbg_o
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  // Handshake: a requester holds req (and its addr/we/wdata) until the
  // one-cycle gnt pulse; read data follows later as a one-cycle rvalid.

  arb_state_e          state_q;
  owner_e              owner_q;
  logic                we_q;
  logic [LAT_W-1:0]    lat_q;
  logic [STV_W-1:0]    starve_q, starve_d;
  logic                pick_ls_d;
  logic                if_gnt_q, ls_gnt_q, if_rvalid_q, ls_rvalid_q;
  logic                mem_en_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q, if_rdata_q, ls_rdata_q;

  function automatic logic pick_ls(input logic if_r, input logic ls_r,
                                   input logic starved);
    return ls_r && !(if_r && starved);
  endfunction

  // Starvation count only moves in IDLE, where arbitration happens.
  always_comb begin
    pick_ls_d = pick_ls(if_req, ls_req, starve_q == STV_W'(STARVE_MAX));
    starve_d  = starve_q;
    if (state_q == ST_IDLE) begin
      if (!if_req || !pick_ls_d) begin
        starve_d = '0;
      end else if (starve_q != STV_W'(STARVE_MAX)) begin
        starve_d = starve_q + STV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      lat_q       <= '0;
      starve_q    <= '0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      starve_q    <= starve_d;
      case (state_q)
        ST_IDLE: begin
          if (if_req || ls_req) begin
            state_q  <= ST_ISSUE;
            mem_en_q <= 1'b1;
            if (pick_ls_d) begin
              owner_q     <= OWN_LS;
              we_q        <= ls_we;
              ls_gnt_q    <= 1'b1;
              mem_we_q    <= ls_we;
              mem_addr_q  <= ls_addr;
              mem_wdata_q <= ls_wdata;
            end else begin
              owner_q    <= OWN_IF;
              we_q       <= 1'b0;
              if_gnt_q   <= 1'b1;
              mem_addr_q <= if_addr;
            end
          end
        end
        ST_ISSUE: begin
          if (we_q) begin
            state_q <= ST_IDLE;
          end else begin
            lat_q   <= LAT_W'(MEM_LAT - 1);
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_q == '0) begin
            state_q <= ST_RESP;
            if (owner_q == OWN_LS) begin
              ls_rdata_q  <= mem_rdata;
              ls_rvalid_q <= 1'b1;
            end else begin
              if_rdata_q  <= mem_rdata;
              if_rvalid_q <= 1'b1;
            end
          end else begin
            lat_q <= lat_q - LAT_W'(1);
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_gnt      = if_gnt_q;
  assign ls_gnt      = ls_gnt_q;
  assign if_rvalid   = if_rvalid_q;
  assign ls_rvalid   = ls_rvalid_q;
  assign if_rdata    = if_rdata_q;
  assign ls_rdata    = ls_rdata_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level timing model predicts
// every grant and read response; a monitor compares what the DUT presents.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int MEM_LAT    = 3;
  localparam int STARVE_MAX = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic              if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0, ls_addr = '0;
  logic [DATA_W-1:0] ls_wdata = '0, mem_rdata = '0;
  logic              if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we;
  logic [DATA_W-1:0] if_rdata, ls_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        state_dbg;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT),
                 .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .state_dbg_o(state_dbg)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- memory array model ----------------
  logic [DATA_W-1:0] mem [256];
  logic [DATA_W-1:0] ref_mem [256];
  typedef struct { int due; logic [DATA_W-1:0] data; } rsp_t;
  rsp_t rsp_q[$];

  always @(negedge clk) begin
    rsp_t r;
    mem_rdata = DATA_W'($urandom_range(0, 255));
    while (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      r = rsp_q.pop_front();
      if (r.due == cyc) mem_rdata = r.data;
    end
    if (!reset && mem_en) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      else begin
        r.due = cyc + MEM_LAT;
        r.data = mem[mem_addr];
        rsp_q.push_back(r);
      end
    end
  end

  // ---------------- reference model + expected queues ----------------
  typedef struct { int cyc; logic who; logic we; logic [ADDR_W-1:0] addr;
                   logic [DATA_W-1:0] wdata; } gnt_t;
  typedef struct { int cyc; logic who; logic [DATA_W-1:0] data; } rv_t;
  gnt_t gnt_q[$];
  rv_t  rv_q[$];

  int free_at = 0;
  int starve  = 0;
  bit drop_if = 0, drop_ls = 0;
  int if_rate = 0, ls_rate = 0;

  // Serial server: one access at a time, fixed occupancy per access type.
  task automatic model_cycle();
    gnt_t g;
    rv_t  v;
    bit   take_ls;
    if (cyc < free_at) return;
    if (!if_req) starve = 0;
    if (!(if_req || ls_req)) return;
    take_ls = ls_req && !(if_req && starve == STARVE_MAX);
    g.cyc = cyc + 1;
    if (take_ls) begin
      if (if_req && starve < STARVE_MAX) starve++;
      g.who = 1'b1; g.we = ls_we; g.addr = ls_addr; g.wdata = ls_wdata;
      drop_ls = 1;
    end else begin
      starve = 0;
      g.who = 1'b0; g.we = 1'b0; g.addr = if_addr; g.wdata = '0;
      drop_if = 1;
    end
    gnt_q.push_back(g);
    if (g.we) begin
      ref_mem[g.addr] = g.wdata;
      free_at = cyc + 2;
    end else begin
      v.cyc = cyc + 2 + MEM_LAT; v.who = g.who; v.data = ref_mem[g.addr];
      rv_q.push_back(v);
      free_at = cyc + MEM_LAT + 3;
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick(input bit f_new = 0, input logic [ADDR_W-1:0] f_addr = '0,
                      input bit l_new = 0, input bit l_we = 0,
                      input logic [ADDR_W-1:0] l_addr = '0,
                      input logic [DATA_W-1:0] l_wd = '0);
    @(negedge clk);
    if (drop_if) begin if_req = 1'b0; drop_if = 0; end
    if (drop_ls) begin ls_req = 1'b0; drop_ls = 0; end
    if (!if_req && f_new) begin if_req = 1'b1; if_addr = f_addr; end
    if (!ls_req && l_new) begin
      ls_req = 1'b1; ls_we = l_we; ls_addr = l_addr; ls_wdata = l_wd;
    end
    if (!if_req && $urandom_range(0, 99) < if_rate) begin
      if_req = 1'b1; if_addr = ADDR_W'($urandom_range(0, 15));
    end
    if (!ls_req && $urandom_range(0, 99) < ls_rate) begin
      ls_req = 1'b1; ls_we = 1'($urandom_range(0, 1));
      ls_addr = ADDR_W'($urandom_range(0, 15)); ls_wdata = DATA_W'($urandom);
    end
    model_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"}, {if_gnt, ls_gnt}, 0);
    check({tag, "_rvalid"}, {if_rvalid, ls_rvalid}, 0);
    check({tag, "_rdata"}, {if_rdata, ls_rdata}, 0);
    check({tag, "_mem_ctl"}, {mem_en, mem_we}, 0);
    check({tag, "_mem_bus"}, {mem_addr, mem_wdata}, 0);
    check({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [DATA_W-1:0] exp_if_d = '0, exp_ls_d = '0;

  always @(negedge clk) begin
    gnt_t g;
    rv_t  v;
    if (reset) begin
      exp_if_d = '0; exp_ls_d = '0;
    end else begin
      if (if_gnt || ls_gnt || mem_en) begin
        if (gnt_q.size() == 0) check("spurious_grant", {if_gnt, ls_gnt, mem_en}, 0);
        else begin
          g = gnt_q.pop_front();
          check("gnt_cycle", cyc, g.cyc);
          check("gnt_owner", {ls_gnt, if_gnt}, g.who ? 2'b10 : 2'b01);
          check("gnt_mem_en", mem_en, 1);
          check("mem_we", mem_we, g.we);
          check("mem_addr", mem_addr, g.addr);
          if (g.we) check("mem_wdata", mem_wdata, g.wdata);
        end
      end
      if (if_rvalid || ls_rvalid) begin
        if (rv_q.size() == 0) check("spurious_rvalid", {if_rvalid, ls_rvalid}, 0);
        else begin
          v = rv_q.pop_front();
          if (v.who) exp_ls_d = v.data; else exp_if_d = v.data;
          check("rv_cycle", cyc, v.cyc);
          check("rv_owner", {ls_rvalid, if_rvalid}, v.who ? 2'b10 : 2'b01);
          check("if_rdata", if_rdata, exp_if_d);
          check("ls_rdata", ls_rdata, exp_ls_d);
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = DATA_W'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    free_at = cyc;

    // lone fetch
    tick(1, 8'h10);
    idle(8);
    check("fetch_rdata_hold", if_rdata, 8'hA5);
    check("fetch_ls_untouched", ls_rdata, 8'h00);

    // lone store, back in IDLE two cycles after sampling
    tick(0, 0, 1, 1, 8'h20, 8'h5A);
    idle(2);
    check("store_idle_c2", state_dbg, ST_IDLE);
    check("store_mem_written", mem[8'h20], 8'h5A);
    idle(4);

    // simultaneous requests: load/store first
    tick(1, 8'h21, 1, 0, 8'h20);
    idle(14);

    // latency sweep load from 0x33
    tick(0, 0, 1, 0, 8'h33);
    idle(8);
    check("load33_rdata", ls_rdata, ref_mem[8'h33]);

    // starvation: both requesters always busy
    if_rate = 100; ls_rate = 100;
    idle(80);
    if_rate = 0; ls_rate = 0;
    idle(12);

    // randomized mix
    if_rate = 30; ls_rate = 40;
    idle(1500);
    if_rate = 0; ls_rate = 0;
    idle(12);

    // reset while the load is in WAIT
    tick(0, 0, 1, 0, 8'h05);
    idle(2);
    check("pre_reset_state", state_dbg, ST_WAIT);
    #1 reset = 1'b1;
    #1 check_outputs_zero("mid_reset");
    gnt_q.delete(); rv_q.delete();
    starve = 0; drop_if = 0; drop_ls = 0;
    if_req = 1'b0; ls_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    free_at = cyc;
    idle(8);
    check("post_reset_no_rvalid_rdata", ls_rdata, 8'h00);
    tick(1, 8'h10);
    idle(8);
    check("post_reset_fetch", if_rdata, ref_mem[8'h10]);

    check("gnt_q_drained", gnt_q.size(), 0);
    check("rv_q_drained", rv_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the CPU's instruction-fetch path and its load/store path. Each access is sequenced through a small FSM: arbitrate, issue one memory cycle, wait the fixed read latency, return read data. Load/store has priority, and a starvation counter guarantees fetch progress. Sits between the core (driven by the FETCH/EXECUTE phases of the control unit) and the memory array.

## Interface
Parameters:
- ADDR_W, 8, address width
- DATA_W, 8, data width
- MEM_LAT, 1, memory read latency in cycles (≥1); mem_rdata is valid MEM_LAT cycles after the mem_en cycle
- STARVE_MAX, 4, maximum consecutive load/store grants while if_req is pending (≥1)

Ports. Clock clk; reset reset, asynchronous, active-high.
- clk  in  1  clock
- reset  in  1  async active-high reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle grant pulse to fetch
- if_rvalid  out  1  one-cycle fetch read-data valid
- if_rdata  out  DATA_W  fetch read data
- ls_req  in  1  load/store request; held until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  load/store address
- ls_wdata  in  DATA_W  store data
- ls_gnt  out  1  one-cycle grant pulse to load/store
- ls_rvalid  out  1  one-cycle load data valid (never pulses for stores)
- ls_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

## Operation
- All outputs are registered. On reset: state IDLE, every output 0, starvation counter 0, owner cleared.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if no request, stay. Otherwise choose a winner and capture its addr/we/wdata and owner ID. Next state is ISSUE.
- Winner rule: ls wins over if, except when if_req=1 and starve_cnt==STARVE_MAX, in which case if wins.
- starve_cnt: increments on an ls grant while if_req=1. It clears on any if grant, or in any IDLE cycle with if_req=0. It saturates at STARVE_MAX.
- ISSUE (1 cycle): mem_en=1, mem_we/mem_addr/mem_wdata driven from the captured values, owner's gnt=1.
  - Store: next state IDLE.
  - Load: the latency counter loads MEM_LAT-1 and the next state is WAIT.
- WAIT: counts down. When the count is 0, sample mem_rdata into the owner's rdata register; next state RESP.
- RESP (1 cycle): owner's rvalid=1, then IDLE.
- rdata holds its last value until the next load for that owner. The non-owner's rdata never changes.
- A fetch is always a read; mem_we=0.
- Requests arriving during ISSUE/WAIT/RESP are not sampled until IDLE.
- A requester that drops req before gnt violates protocol. The captured access still completes.
- Reset mid-access: the access is abandoned and no rvalid is generated. The memory write, if already issued, stands.

## Timing
- Request sampled in IDLE at cycle c. Then: mem_en/gnt at c+1; mem_rdata valid at c+1+MEM_LAT; rvalid/rdata at c+2+MEM_LAT.
- Store occupancy is 2 cycles (IDLE, ISSUE). Load occupancy is MEM_LAT+3 cycles.
- No overlap between accesses. Exactly one mem_en pulse per grant.
- gnt and mem_en are coincident. At most one of if_gnt/ls_gnt is high per cycle, and at most one rvalid is high per cycle.

## Structure
- Shared core package/header (cpu_defs): state encodings for IDLE/ISSUE/WAIT/RESP and owner IDs OWN_IF/OWN_LS, alongside the control-unit state constants.
- Single module; no sub-module. The winner selection is an internal function. The latency counter is $clog2(MEM_LAT+1) bits.

## Test plan
- Lone fetch, MEM_LAT=1: if_req=1, if_addr=0x10 at c0, mem returns 0xA5 → mem_en/if_gnt at c1 with mem_addr=0x10; if_rvalid=1, if_rdata=0xA5 at c3; ls outputs unchanged.
- Store: ls_req=1, ls_we=1, ls_addr=0x20, ls_wdata=0x5A → mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0x5A for one cycle; no ls_rvalid; state back to IDLE at c2.
- Simultaneous requests: both requests at c0 → ls_gnt at c1, if_gnt only after the ls access completes.
- Starvation, STARVE_MAX=4: ls_req and if_req held continuously → 4 consecutive ls grants, then if_gnt, then ls again.
- Latency sweep, MEM_LAT=3: load from 0x33 → rvalid exactly 5 cycles after request sampling; rdata equals mem_rdata at c4.
- Reset asserted during WAIT → all outputs 0 immediately, no rvalid after release; next request is served normally.
